rv_commit_tracer: RTL and testbench
===================================

# rv_commit_tracer

Synthesizable commit-trace capture unit for the RV core family. It records one entry per retired instruction (PC, instruction, destination register, write-back data, flags) into a parametrised circular trace buffer. It stops capture on a cycle limit, a self-loop, ECALL/EBREAK, or buffer-full, and drains entries over a valid/ready readout port. It attaches beside a core's commit point and replaces fixed-length per-cycle printing with bounded, hardware-side trace collection usable both in simulation and on FPGA.

## Interface
- XLEN, 32: width of PC, instruction and data fields
- DEPTH, 16: trace entries; power of two, ≥2
- MAX_COMMITS, 75: commits captured before halting with reason LIMIT; 16-bit counter
- LOOP_LIMIT, 4: consecutive commits with identical PC that trigger halt reason LOOP; ≥2
- WRAP_MODE, 0: 0 = stop when full; 1 = overwrite oldest entry when full
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms a new capture
- commit_valid  in  1  an instruction retires this cycle
- commit_pc  in  XLEN  PC of the retiring instruction
- commit_instr  in  32  instruction word
- commit_rd  in  5  destination register index
- commit_wb_data  in  XLEN  write-back result
- commit_reg_write  in  1  register write enable
- commit_mem_write  in  1  memory write enable
- rd_valid  out  1  buffer non-empty
- rd_ready  in  1  consumer accepts the head entry
- rd_pc, rd_instr, rd_wb_data  out  XLEN/32/XLEN  head entry fields
- rd_rd  out  5  head entry destination register
- rd_flags  out  2  {mem_write, reg_write} of the head entry
- state  out  2  0 IDLE, 1 CAPTURE, 2 DRAIN, 3 DONE
- commit_count  out  16  commits accepted since start
- entry_count  out  clog2(DEPTH)+1  current occupancy
- dropped  out  16  entries overwritten (WRAP_MODE=1); saturates at 0xFFFF
- halt_reason  out  3  0 none, 1 LIMIT, 2 LOOP, 3 ECALL/EBREAK, 4 FULL
- done  out  1  high in DONE

## Operation
- Reset: state IDLE; all counters, pointers, halt_reason and dropped are 0; rd_valid 0; done 0.
- IDLE/DONE + start: clear pointers, counters, halt_reason, dropped, and the loop tracker; go to CAPTURE. start is ignored in CAPTURE and DRAIN.
- CAPTURE + commit_valid: write the entry at wr_ptr and increment commit_count.
- Loop tracker: a run counter resets to 1 when the PC differs from the previous commit's PC and increments when it matches.
- Halt checks use the current commit, and the halting commit is itself recorded. Conditions:
  - instr == 0x00000073 or 0x00100073 → ECALL/EBREAK.
  - run counter reaches LOOP_LIMIT → LOOP.
  - commit_count reaches MAX_COMMITS → LIMIT.
- Halt priority when several conditions hit together: ECALL/EBREAK > LOOP > LIMIT > FULL.
- WRAP_MODE=0: a write that makes occupancy DEPTH halts with FULL. Commits after any halt are ignored.
- WRAP_MODE=1, buffer full, push without pop: overwrite the oldest entry, advance rd_ptr, increment dropped. Occupancy stays DEPTH.
- Push and pop in the same cycle: both take effect with no overwrite, and occupancy is unchanged, including when full.
- Halt moves the state CAPTURE → DRAIN on the same edge. DRAIN → DONE on the edge where occupancy becomes 0. If the buffer is already empty at halt, DRAIN lasts one cycle.
- Readout is a show-ahead FIFO: the rd_* fields show mem[rd_ptr] combinationally, and a pop happens on rd_valid & rd_ready. Popping is legal in CAPTURE, DRAIN and DONE. In DONE the buffer is empty, so no pop occurs.
- Pointers wrap modulo DEPTH.

## Timing
- Push to rd_valid: 1 cycle. An entry written at edge N is visible after edge N.
- Halt to state change: same edge as the halting commit. done asserts the edge occupancy reaches 0 in DRAIN.
- Pop: head advances on the accepting edge, so the next entry is visible in the following cycle. Full throughput is 1 entry/cycle.
- rst_n assertion mid-capture or mid-drain clears all state asynchronously. Buffer contents are discarded, and only counters/pointers need reset.

## Test plan
- Basic capture: start, then 5 commits at PCs 0x0,0x4,…,0x10, rd_ready=0 → entry_count=5, commit_count=5, state CAPTURE. Then rd_ready=1 → entries pop in order, rd_pc 0x0…0x10.
- Limit, MAX_COMMITS=8, DEPTH=16: 10 commits → 8 recorded, halt_reason=1. Draining 8 entries → state DONE, done=1.
- Loop: commits at 0x0, 0x4, then 0x8 repeated, LOOP_LIMIT=4 → halt after the 4th 0x8 commit. halt_reason=2, 6 entries stored.
- Full/wrap, DEPTH=4, MAX_COMMITS large, 6 commits at distinct PCs, no pops:
  - WRAP_MODE=0 → halt_reason=4 after the 4th commit; entries are PCs 0x0–0xC.
  - WRAP_MODE=1 → dropped=2, head rd_pc=0x8, entry_count=4.
- Simultaneous events: EBREAK (0x00100073) on the commit that also reaches MAX_COMMITS → halt_reason=3. Push+pop while full in WRAP_MODE=1 → dropped unchanged.
- Reset mid-drain: assert rst_n=0 with 3 entries pending → state IDLE, rd_valid=0, counts 0 immediately. Then start → a fresh capture works.

Source files
------------

// File: rtl/rv_commit_tracer.sv
// Commit-trace capture unit: one entry per retired instruction goes into a circular buffer.
// Capture stops on a cycle limit, a self-loop, ECALL/EBREAK or a full buffer; a show-ahead port drains it.
module rv_commit_tracer #(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_COMMITS = 75,
  parameter int LOOP_LIMIT  = 4,
  parameter int WRAP_MODE   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [4:0]               commit_rd,
  input  logic [XLEN-1:0]          commit_wb_data,
  input  logic                     commit_reg_write,
  input  logic                     commit_mem_write,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [XLEN-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [XLEN-1:0]          rd_wb_data,
  output logic [4:0]               rd_rd,
  output logic [1:0]               rd_flags,
  output logic [1:0]               state,
  output logic [15:0]              commit_count,
  output logic [$clog2(DEPTH):0]   entry_count,
  output logic [15:0]              dropped,
  output logic [2:0]               halt_reason,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t           state_q;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_next;
  logic [15:0]      run_q, run_next, cc_next;
  logic [XLEN-1:0]  prev_pc;
  logic             have_prev;
  logic [2:0]       halt_code;
  logic             push, pop, full, overwrite, is_sys;

  logic [XLEN-1:0]  mem_pc   [DEPTH];
  logic [31:0]      mem_inst [DEPTH];
  logic [XLEN-1:0]  mem_wb   [DEPTH];
  logic [4:0]       mem_rd   [DEPTH];
  logic [1:0]       mem_fl   [DEPTH];

  // Handshake: an entry leaves the buffer on any cycle where rd_valid and rd_ready are both high.
  assign rd_valid  = (count_q != '0);
  assign pop       = rd_valid && rd_ready;
  assign push      = (state_q == S_CAPTURE) && commit_valid;
  assign full      = (count_q == CW'(DEPTH));
  assign overwrite = push && !pop && full && (WRAP_MODE != 0);
  assign is_sys    = (commit_instr == 32'h0000_0073) || (commit_instr == 32'h0010_0073);
  assign run_next  = (have_prev && commit_pc == prev_pc) ? run_q + 16'd1 : 16'd1;
  assign cc_next   = commit_count + 16'd1;

  always_comb begin
    count_next = count_q;
    if (push && !pop && !overwrite) count_next = count_q + CW'(1);
    else if (pop && !push)          count_next = count_q - CW'(1);
  end

  always_comb begin
    halt_code = 3'd0;
    if (is_sys)                                             halt_code = 3'd3;
    else if (run_next == 16'(LOOP_LIMIT))                   halt_code = 3'd2;
    else if (cc_next == 16'(MAX_COMMITS))                   halt_code = 3'd1;
    else if (WRAP_MODE == 0 && count_next == CW'(DEPTH))    halt_code = 3'd4;
  end

  // Buffer contents are never reset; only pointers and counts decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= commit_pc;
      mem_inst[wr_ptr] <= commit_instr;
      mem_wb[wr_ptr]   <= commit_wb_data;
      mem_rd[wr_ptr]   <= commit_rd;
      mem_fl[wr_ptr]   <= {commit_mem_write, commit_reg_write};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      commit_count <= '0;
      dropped      <= '0;
      halt_reason  <= '0;
      run_q        <= '0;
      prev_pc      <= '0;
      have_prev    <= 1'b0;
      done         <= 1'b0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      state_q      <= S_CAPTURE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      commit_count <= '0;
      dropped      <= '0;
      halt_reason  <= '0;
      run_q        <= '0;
      prev_pc      <= '0;
      have_prev    <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + AW'(1);
        commit_count <= cc_next;
        run_q        <= run_next;
        prev_pc      <= commit_pc;
        have_prev    <= 1'b1;
      end
      if (pop || overwrite) rd_ptr <= rd_ptr + AW'(1);
      if (overwrite && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      count_q <= count_next;
      case (state_q)
        S_CAPTURE: if (push && halt_code != 3'd0) begin
          halt_reason <= halt_code;
          state_q     <= S_DRAIN;
        end
        S_DRAIN: if (count_next == '0) begin
          state_q <= S_DONE;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign entry_count = count_q;
  assign rd_pc       = mem_pc[rd_ptr];
  assign rd_instr    = mem_inst[rd_ptr];
  assign rd_wb_data  = mem_wb[rd_ptr];
  assign rd_rd       = mem_rd[rd_ptr];
  assign rd_flags    = mem_fl[rd_ptr];
endmodule

// File: tb/tb_rv_commit_tracer.sv
// Directed bench for rv_commit_tracer: three instances cover limit/loop/syscall, stop-on-full and wrap.
module tb_rv_commit_tracer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        c_valid, c_rw, c_mw;
  logic [31:0] c_pc, c_instr, c_wb;
  logic [4:0]  c_rd;
  logic        start_a, start_b, start_c, rdy_a, rdy_b, rdy_c;

  logic        rv_a, rv_b, rv_c, done_a, done_b, done_c;
  logic [31:0] pc_a, pc_b, pc_c, in_a, in_b, in_c, wb_a, wb_b, wb_c;
  logic [4:0]  rr_a, rr_b, rr_c;
  logic [1:0]  fl_a, fl_b, fl_c, st_a, st_b, st_c;
  logic [15:0] cc_a, cc_b, cc_c, dr_a, dr_b, dr_c;
  logic [4:0]  ec_a;
  logic [2:0]  ec_b, ec_c;
  logic [2:0]  hr_a, hr_b, hr_c;

  int total = 0;
  int bad = 0;

  rv_commit_tracer #(.XLEN(32), .DEPTH(16), .MAX_COMMITS(8), .LOOP_LIMIT(4), .WRAP_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .commit_valid(c_valid), .commit_pc(c_pc),
    .commit_instr(c_instr), .commit_rd(c_rd), .commit_wb_data(c_wb), .commit_reg_write(c_rw),
    .commit_mem_write(c_mw), .rd_valid(rv_a), .rd_ready(rdy_a), .rd_pc(pc_a), .rd_instr(in_a),
    .rd_wb_data(wb_a), .rd_rd(rr_a), .rd_flags(fl_a), .state(st_a), .commit_count(cc_a),
    .entry_count(ec_a), .dropped(dr_a), .halt_reason(hr_a), .done(done_a));

  rv_commit_tracer #(.XLEN(32), .DEPTH(4), .MAX_COMMITS(1000), .LOOP_LIMIT(4), .WRAP_MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .commit_valid(c_valid), .commit_pc(c_pc),
    .commit_instr(c_instr), .commit_rd(c_rd), .commit_wb_data(c_wb), .commit_reg_write(c_rw),
    .commit_mem_write(c_mw), .rd_valid(rv_b), .rd_ready(rdy_b), .rd_pc(pc_b), .rd_instr(in_b),
    .rd_wb_data(wb_b), .rd_rd(rr_b), .rd_flags(fl_b), .state(st_b), .commit_count(cc_b),
    .entry_count(ec_b), .dropped(dr_b), .halt_reason(hr_b), .done(done_b));

  rv_commit_tracer #(.XLEN(32), .DEPTH(4), .MAX_COMMITS(1000), .LOOP_LIMIT(4), .WRAP_MODE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .commit_valid(c_valid), .commit_pc(c_pc),
    .commit_instr(c_instr), .commit_rd(c_rd), .commit_wb_data(c_wb), .commit_reg_write(c_rw),
    .commit_mem_write(c_mw), .rd_valid(rv_c), .rd_ready(rdy_c), .rd_pc(pc_c), .rd_instr(in_c),
    .rd_wb_data(wb_c), .rd_rd(rr_c), .rd_flags(fl_c), .state(st_c), .commit_count(cc_c),
    .entry_count(ec_c), .dropped(dr_c), .halt_reason(hr_c), .done(done_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    if (which == 0) start_a = 1'b1;
    if (which == 1) start_b = 1'b1;
    if (which == 2) start_c = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
    c_valid = 1'b1;
    c_pc    = pc;
    c_instr = instr;
    c_rd    = pc[6:2];
    c_wb    = pc ^ 32'hA5A5_0000;
    c_rw    = 1'b1;
    c_mw    = pc[2];
    step();
    c_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0;
    {c_valid, c_rw, c_mw, c_pc, c_instr, c_wb, c_rd} = '0;
    {start_a, start_b, start_c, rdy_a, rdy_b, rdy_c} = '0;
    #12;
    chk("reset_state", 32'(st_a), 32'd0);
    chk("reset_rd_valid", 32'(rv_a), 32'd0);
    chk("reset_entry_count", 32'(ec_a), 32'd0);
    chk("reset_commit_count", 32'(cc_a), 32'd0);
    chk("reset_halt", 32'(hr_a), 32'd0);
    chk("reset_dropped", 32'(dr_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic capture then in-order drain
    pulse(0);
    chk("basic_state_capture", 32'(st_a), 32'd1);
    for (int i = 0; i < 5; i++) commit(32'(i * 4), 32'h0000_0013);
    chk("basic_entry_count", 32'(ec_a), 32'd5);
    chk("basic_commit_count", 32'(cc_a), 32'd5);
    chk("basic_state", 32'(st_a), 32'd1);
    rdy_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 32'(i * 4);
      chk("basic_rd_pc", rd_pc_a(), pc);
      chk("basic_rd_wb", wb_a, pc ^ 32'hA5A5_0000);
      chk("basic_rd_rd", 32'(rr_a), 32'(i));
      chk("basic_rd_flags", 32'(fl_a), {30'd0, pc[2], 1'b1});
      chk("basic_rd_instr", in_a, 32'h0000_0013);
      step();
    end
    rdy_a = 1'b0;
    chk("basic_empty", 32'(rv_a), 32'd0);
    chk("basic_still_capture", 32'(st_a), 32'd1);

    // Limit: 10 commits, only 8 accepted
    do_reset();
    pulse(0);
    for (int i = 0; i < 10; i++) commit(32'h100 + 32'(i * 4), 32'h0000_0013);
    chk("limit_commit_count", 32'(cc_a), 32'd8);
    chk("limit_entry_count", 32'(ec_a), 32'd8);
    chk("limit_halt", 32'(hr_a), 32'd1);
    chk("limit_state_drain", 32'(st_a), 32'd2);
    chk("limit_done_low", 32'(done_a), 32'd0);
    rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("limit_rd_pc", pc_a, 32'h100 + 32'(i * 4));
      step();
    end
    rdy_a = 1'b0;
    chk("limit_state_done", 32'(st_a), 32'd3);
    chk("limit_done", 32'(done_a), 32'd1);
    chk("limit_empty", 32'(ec_a), 32'd0);

    // Loop: 0x0, 0x4, then 0x8 four times
    pulse(0);
    chk("loop_restart", 32'(st_a), 32'd1);
    chk("loop_cleared_halt", 32'(hr_a), 32'd0);
    commit(32'h0, 32'h0000_0013);
    commit(32'h4, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      commit(32'h8, 32'h0000_006F);
      chk("loop_no_early_halt", 32'(st_a), 32'd1);
    end
    commit(32'h8, 32'h0000_006F);
    chk("loop_halt", 32'(hr_a), 32'd2);
    chk("loop_entries", 32'(ec_a), 32'd6);
    chk("loop_state", 32'(st_a), 32'd2);
    commit(32'h200, 32'h0000_0013);
    chk("loop_ignored_entries", 32'(ec_a), 32'd6);
    chk("loop_ignored_count", 32'(cc_a), 32'd6);
    rdy_a = 1'b1;
    for (int i = 0; i < 6; i++) step();
    rdy_a = 1'b0;
    chk("loop_done", 32'(done_a), 32'd1);

    // EBREAK on the commit that also reaches MAX_COMMITS
    pulse(0);
    for (int i = 0; i < 7; i++) commit(32'h300 + 32'(i * 4), 32'h0000_0013);
    chk("sys_pre_state", 32'(st_a), 32'd1);
    commit(32'h31C, 32'h0010_0073);
    chk("sys_halt_priority", 32'(hr_a), 32'd3);
    chk("sys_count", 32'(cc_a), 32'd8);
    chk("sys_entries", 32'(ec_a), 32'd8);

    // Reset mid-drain with 3 entries pending
    rdy_a = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rdy_a = 1'b0;
    chk("middrain_pending", 32'(ec_a), 32'd3);
    chk("middrain_state", 32'(st_a), 32'd2);
    chk("middrain_head", pc_a, 32'h314);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st_a), 32'd0);
    chk("arst_rd_valid", 32'(rv_a), 32'd0);
    chk("arst_entry_count", 32'(ec_a), 32'd0);
    chk("arst_commit_count", 32'(cc_a), 32'd0);
    chk("arst_halt", 32'(hr_a), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    pulse(0);
    commit(32'h40, 32'h0000_0073);
    chk("fresh_halt", 32'(hr_a), 32'd3);
    chk("fresh_entries", 32'(ec_a), 32'd1);
    chk("fresh_head", pc_a, 32'h40);
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    chk("fresh_done", 32'(st_a), 32'd3);

    // Stop on full, DEPTH=4
    pulse(1);
    for (int i = 0; i < 6; i++) begin
      commit(32'(i * 4), 32'h0000_0013);
      if (i == 2) chk("full_not_yet", 32'(st_b), 32'd1);
    end
    chk("full_halt", 32'(hr_b), 32'd4);
    chk("full_entries", 32'(ec_b), 32'd4);
    chk("full_count", 32'(cc_b), 32'd4);
    chk("full_state", 32'(st_b), 32'd2);
    rdy_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_rd_pc", pc_b, 32'(i * 4));
      step();
    end
    rdy_b = 1'b0;
    chk("full_done", 32'(done_b), 32'd1);

    // Wrap mode, DEPTH=4: oldest two overwritten
    pulse(2);
    for (int i = 0; i < 6; i++) commit(32'(i * 4), 32'h0000_0013);
    chk("wrap_dropped", 32'(dr_c), 32'd2);
    chk("wrap_head", pc_c, 32'h8);
    chk("wrap_entries", 32'(ec_c), 32'd4);
    chk("wrap_halt_none", 32'(hr_c), 32'd0);
    chk("wrap_state", 32'(st_c), 32'd1);
    rdy_c = 1'b1;
    commit(32'h18, 32'h0000_0013);
    rdy_c = 1'b0;
    chk("wrap_pushpop_dropped", 32'(dr_c), 32'd2);
    chk("wrap_pushpop_entries", 32'(ec_c), 32'd4);
    chk("wrap_pushpop_head", pc_c, 32'hC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [31:0] rd_pc_a();
    return pc_a;
  endfunction
endmodule
